// File: rtl/line_buffer_3x3.sv
// line_buffer_3x3: streaming 3x3 sliding-window generator over one uint8 raster plane.
// Build macro LB_STRIDE2_EN adds a stride2 input that keeps only even window positions.
module line_buffer_3x3 #(
  parameter int MAX_WIDTH = 320,
  parameter int DIM_W     = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  input  logic             start,
`ifdef LB_STRIDE2_EN
  input  logic             stride2,
`endif
  input  logic [7:0]       pixel_in,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic [71:0]      window_out,
  output logic             window_valid,
  input  logic             window_ready,
  output logic             frame_done,
  output logic             cfg_error,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [DIM_W-1:0] ZERO_C  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0] ONE_C   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO_C   = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE_C = DIM_W'(3);
  localparam logic [DIM_W-1:0] MAX_W_C = DIM_W'(MAX_WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [DIM_W-1:0] width_r;
  logic [DIM_W-1:0] height_r;
  logic [DIM_W-1:0] col_r;
  logic [DIM_W-1:0] row_r;
  logic [71:0]      window_r;
  logic             window_valid_r;
  logic             cfg_error_r;

  logic [7:0]       mem_a [0:MAX_WIDTH-1];
  logic [7:0]       mem_b [0:MAX_WIDTH-1];

  logic             pixel_ready_s;
  logic             xfer_s;
  logic             cfg_ok_s;
  logic             accept_start_s;
  logic             last_col_s;
  logic             last_row_s;
  logic             emit_s;
  logic             stride_ok_s;
  logic [7:0]       top_s;
  logic [7:0]       mid_s;
  logic [71:0]      win_next_s;

  assign cfg_ok_s       = (img_width >= THREE_C) && (img_width <= MAX_W_C) && (img_height >= THREE_C);
  assign accept_start_s = (state_r == IDLE) && start && cfg_ok_s;
  assign pixel_ready_s  = ((state_r == FILL) || (state_r == STREAM)) && (!window_valid_r || window_ready);
  assign xfer_s         = pixel_valid && pixel_ready_s;
  assign last_col_s     = (col_r == (width_r - ONE_C));
  assign last_row_s     = (row_r == (height_r - ONE_C));
  assign top_s          = mem_a[col_r];
  assign mid_s          = mem_b[col_r];

`ifdef LB_STRIDE2_EN
  logic stride_r;

  // Stride mode is latched with the frame dimensions on an accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      stride_r <= 1'b0;
    end else if (accept_start_s) begin
      stride_r <= stride2;
    end else begin
      stride_r <= stride_r;
    end
  end

  // row-2 and col-2 are even exactly when row and col are even.
  assign stride_ok_s = !stride_r || (!row_r[0] && !col_r[0]);
`else
  assign stride_ok_s = 1'b1;
`endif

  assign emit_s = (row_r >= TWO_C) && (col_r >= TWO_C) && stride_ok_s;

  // Each row shifts left; the new right column is {A[c], B[c], pixel_in}. Byte i sits at [8i +: 8].
  assign win_next_s = {pixel_in, window_r[71:64], window_r[63:56],
                       mid_s,    window_r[47:40], window_r[39:32],
                       top_s,    window_r[23:16], window_r[15:8]};

  // Frame-sequencing next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_start_s) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (xfer_s && (row_r == TWO_C) && (col_r == ZERO_C)) begin
          state_s = STREAM;
        end else begin
          state_s = FILL;
        end
      end
      STREAM: begin
        if (xfer_s && last_col_s && last_row_s) begin
          state_s = DRAIN;
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (!window_valid_r || window_ready) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counters, window shift register and output handshake registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      width_r        <= ZERO_C;
      height_r       <= ZERO_C;
      col_r          <= ZERO_C;
      row_r          <= ZERO_C;
      window_r       <= 72'd0;
      window_valid_r <= 1'b0;
      cfg_error_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cfg_error_r <= (state_r == IDLE) && start && !cfg_ok_s;

      if (accept_start_s) begin
        width_r  <= img_width;
        height_r <= img_height;
        col_r    <= ZERO_C;
        row_r    <= ZERO_C;
      end else if (xfer_s) begin
        if (last_col_s) begin
          col_r <= ZERO_C;
          row_r <= last_row_s ? ZERO_C : (row_r + ONE_C);
        end else begin
          col_r <= col_r + ONE_C;
          row_r <= row_r;
        end
      end else begin
        col_r <= col_r;
        row_r <= row_r;
      end

      // A transfer only happens when no window is stalled, so window_r doubles as the held output.
      if (xfer_s) begin
        window_r <= win_next_s;
      end else begin
        window_r <= window_r;
      end

      if (xfer_s && emit_s) begin
        window_valid_r <= 1'b1;
      end else if (window_ready) begin
        window_valid_r <= 1'b0;
      end else begin
        window_valid_r <= window_valid_r;
      end
    end
  end

  // Line memories: A ages to row r-2 by taking B's old entry, B takes the incoming pixel.
  always_ff @(posedge clock) begin
    if (xfer_s) begin
      mem_a[col_r] <= mem_b[col_r];
      mem_b[col_r] <= pixel_in;
    end
  end

  assign pixel_ready  = pixel_ready_s;
  assign window_out   = window_r;
  assign window_valid = window_valid_r;
  assign frame_done   = (state_r == DONE);
  assign cfg_error    = cfg_error_r;
  assign busy         = (state_r == FILL) || (state_r == STREAM) || (state_r == DRAIN);

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench for line_buffer_3x3: expected windows are queued when a frame is driven
// and compared in order as the DUT hands them over.
`timescale 1ns/1ps
module tb_line_buffer_3x3;
  localparam int MAX_WIDTH = 320;
  localparam int DIM_W     = 9;

  logic             clock = 1'b0;
  logic             reset;
  logic [DIM_W-1:0] img_width;
  logic [DIM_W-1:0] img_height;
  logic             start;
`ifdef LB_STRIDE2_EN
  logic             stride2;
`endif
  logic [7:0]       pixel_in;
  logic             pixel_valid;
  logic             pixel_ready;
  logic [71:0]      window_out;
  logic             window_valid;
  logic             window_ready;
  logic             frame_done;
  logic             cfg_error;
  logic             busy;

  logic [71:0] exp_q[$];
  logic [71:0] mon_exp;
  int total = 0;
  int bad = 0;
  int n_win = 0;
  int fd_cnt = 0;
  int waits = 0;

  line_buffer_3x3 #(.MAX_WIDTH(MAX_WIDTH), .DIM_W(DIM_W)) dut (
    .clock(clock), .reset(reset), .img_width(img_width), .img_height(img_height),
    .start(start),
`ifdef LB_STRIDE2_EN
    .stride2(stride2),
`endif
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .window_out(window_out), .window_valid(window_valid), .window_ready(window_ready),
    .frame_done(frame_done), .cfg_error(cfg_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int base, input int w, input int r, input int c);
    return 8'(base + r * w + c);
  endfunction

  // Scoreboard side: a window is handed over on an edge where valid and ready are both high.
  always @(negedge clock) begin
    if (!reset && window_valid && window_ready) begin
      n_win++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("window", window_out, mon_exp);
      end
    end
    if (!reset && frame_done) fd_cnt++;
  end

  task automatic push_expected(input int w, input int h, input int base, input int s);
    logic [71:0] v;
    for (int r = 0; r < h - 2; r++)
      for (int c = 0; c < w - 2; c++)
        if (s == 0 || (r % 2 == 0 && c % 2 == 0)) begin
          v = 72'd0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              v[8*(3*i+j) +: 8] = pix(base, w, r + i, c + j);
          exp_q.push_back(v);
        end
  endtask

  task automatic start_frame(input int w, input int h, input int s);
    @(posedge clock); #1;
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
`ifdef LB_STRIDE2_EN
    stride2 = s[0];
`endif
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int w, input int base, input int n);
    int b;
    for (int k = 0; k < n; k++) begin
      pixel_in    = pix(base, w, k / w, k % w);
      pixel_valid = 1'b1;
      b = 0;
      @(negedge clock);
      while (!pixel_ready && b < 100) begin
        b++;
        waits++;
        @(negedge clock);
      end
      check("px_ready", 72'(pixel_ready), 72'd1);
      if (b >= 100) begin
        pixel_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int base, input int s, input int nexp);
    int b;
    n_win = 0;
    fd_cnt = 0;
    waits = 0;
    push_expected(w, h, base, s);
    start_frame(w, h, s);
    check("busy_run", 72'(busy), 72'd1);
    send_pixels(w, base, w * h);
    check("lastwin_valid", 72'(window_valid), 72'd1);
    b = 0;
    while (fd_cnt == 0 && b < 50) begin
      b++;
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    check("frame_done", 72'(fd_cnt), 72'd1);
    check("busy_after", 72'(busy), 72'd0);
    check("win_count", 72'(n_win), 72'(nexp));
    check("q_empty", 72'(exp_q.size()), 72'd0);
  endtask

  task automatic bad_start(input int w, input int h);
    @(posedge clock); #1;
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("cfg_err", 72'(cfg_error), 72'd1);
    check("cfg_busy", 72'(busy), 72'd0);
    @(posedge clock); #1;
    check("cfg_pulse", 72'(cfg_error), 72'd0);
    check("cfg_idle", 72'(busy), 72'd0);
  endtask

  task automatic stall_once();
    int b;
    logic [71:0] held;
    b = 0;
    @(posedge clock); #1;
    while (!(window_valid && n_win == 1) && b < 100) begin
      b++;
      @(posedge clock); #1;
    end
    check("stall_seen", 72'(window_valid), 72'd1);
    window_ready = 1'b0;
    held = window_out;
    repeat (3) begin
      @(posedge clock); #1;
      check("stall_ready", 72'(pixel_ready), 72'd0);
      check("stall_valid", 72'(window_valid), 72'd1);
      check("stall_hold", window_out, held);
    end
    window_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    img_width = '0;
    img_height = '0;
`ifdef LB_STRIDE2_EN
    stride2 = 1'b0;
`endif
    pixel_in = 8'd0;
    pixel_valid = 1'b0;
    window_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_valid", 72'(window_valid), 72'd0);
    check("rst_ready", 72'(pixel_ready), 72'd0);
    check("rst_window", window_out, 72'd0);
    reset = 1'b0;

    // 4x4 frame, full throughput
    run_frame(4, 4, 0, 0, 4);
    check("throughput", 72'(waits), 72'd0);

    // minimum 3x3 frame
    run_frame(3, 3, 10, 0, 1);

    // backpressure on the second window of a 5x4 frame
    fork
      run_frame(5, 4, 50, 0, 6);
      stall_once();
    join

    // rejected configurations, then a legal frame
    bad_start(2, 4);
    bad_start(MAX_WIDTH + 1, 4);
    bad_start(4, 2);
    run_frame(4, 4, 200, 0, 4);

    // reset after 7 pixels of a 4x4 frame
    n_win = 0;
    push_expected(4, 4, 100, 0);
    start_frame(4, 4, 0);
    send_pixels(4, 100, 7);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_window", window_out, 72'd0);
    check("mid_rst_valid", 72'(window_valid), 72'd0);
    check("mid_rst_ready", 72'(pixel_ready), 72'd0);
    check("mid_rst_busy", 72'(busy), 72'd0);
    check("mid_rst_done", 72'(frame_done), 72'd0);
    check("mid_rst_cfg", 72'(cfg_error), 72'd0);
    check("mid_rst_nowin", 72'(n_win), 72'd0);
    reset = 1'b0;
    exp_q.delete();
    run_frame(4, 4, 30, 0, 4);

`ifdef LB_STRIDE2_EN
    // stride 2: top-left pixels 0, 2, 10, 12
    run_frame(5, 5, 0, 1, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
